// File: rtl/trace_sequencer_if.sv
// Bus between the trace sequencer and its consumer: load port, playback control, and the presented trace word.
// The master drives load/control/fetch. The slave (the sequencer) drives the trace word and status.
interface trace_sequencer_if #(
    parameter int N_PA_BITS  = 32,
    parameter int DEPTH_BITS = 14
);
    logic                  load_en;
    logic [DEPTH_BITS-1:0] load_addr;
    logic [N_PA_BITS:0]    load_data;
    logic [DEPTH_BITS:0]   trace_len;
    logic                  start;
    logic                  stop;
    logic                  fetch;
    logic [N_PA_BITS:0]    instruction;
    logic                  halt;
    logic                  done;
    logic [DEPTH_BITS-1:0] prog_count;
    logic [DEPTH_BITS-1:0] read_count;
    logic [DEPTH_BITS-1:0] write_count;
    logic [7:0]            wrap_count;

    modport master (
        output load_en, load_addr, load_data, trace_len, start, stop, fetch,
        input  instruction, halt, done, prog_count, read_count, write_count, wrap_count
    );

    modport slave (
        input  load_en, load_addr, load_data, trace_len, start, stop, fetch,
        output instruction, halt, done, prog_count, read_count, write_count, wrap_count
    );
endinterface

// File: rtl/trace_sequencer.sv
// Trace memory playback source for the cache controller. Each word is {rw, physical address}, and the trace advances once per rising edge of fetch.
// Optional macro TRACE_LOOP_EN: wrap to entry 0 after the last entry instead of finishing.
module trace_sequencer #(
    parameter int N_PA_BITS  = 32,
    parameter int DEPTH_BITS = 14
) (
    input  logic               clk,
    input  logic               reset,
    trace_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t                r_state, w_state_nxt;
    logic [N_PA_BITS:0]    r_mem [2**DEPTH_BITS];
    logic [N_PA_BITS:0]    r_instr, w_instr_nxt;
    logic [DEPTH_BITS-1:0] r_pc, w_pc_nxt;
    logic [DEPTH_BITS-1:0] r_rd, w_rd_nxt;
    logic [DEPTH_BITS-1:0] r_wr, w_wr_nxt;
    logic [DEPTH_BITS:0]   r_len, w_len_nxt;
    logic                  r_fetch_q;
    logic                  w_fetch_rise;
    logic [DEPTH_BITS:0]   w_pc_inc;
    logic [DEPTH_BITS-1:0] w_rd_addr;
    logic [N_PA_BITS:0]    w_mem_word;
    logic [7:0]            r_wrap, w_wrap_nxt;

    assign w_fetch_rise = bus.fetch & ~r_fetch_q;
    assign w_pc_inc     = {1'b0, r_pc} + (DEPTH_BITS+1)'(1);
    // The only read other than entry 0 is the advance to the next entry while running.
    assign w_rd_addr    = (r_state == ST_RUN) ? w_pc_inc[DEPTH_BITS-1:0] : '0;
    assign w_mem_word   = r_mem[w_rd_addr];

    // Loads are locked out while running so the trace under playback cannot change.
    always_ff @(posedge clk) begin
        if (bus.load_en && (r_state != ST_RUN))
            r_mem[bus.load_addr] <= bus.load_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_instr   <= '0;
            r_pc      <= '0;
            r_rd      <= '0;
            r_wr      <= '0;
            r_len     <= '0;
            r_fetch_q <= 1'b0;
            r_wrap    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_instr   <= w_instr_nxt;
            r_pc      <= w_pc_nxt;
            r_rd      <= w_rd_nxt;
            r_wr      <= w_wr_nxt;
            r_len     <= w_len_nxt;
            r_fetch_q <= bus.fetch;
            r_wrap    <= w_wrap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_instr_nxt = r_instr;
        w_pc_nxt    = r_pc;
        w_rd_nxt    = r_rd;
        w_wr_nxt    = r_wr;
        w_len_nxt   = r_len;
        w_wrap_nxt  = r_wrap;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_len_nxt = bus.trace_len;
                    if (bus.trace_len != '0) begin
                        w_state_nxt = ST_RUN;
                        w_instr_nxt = w_mem_word;
                        w_pc_nxt    = '0;
                        w_rd_nxt    = '0;
                        w_wr_nxt    = '0;
                        w_wrap_nxt  = '0;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (w_fetch_rise) begin
                    if (r_instr[N_PA_BITS])
                        w_wr_nxt = r_wr + DEPTH_BITS'(1);
                    else
                        w_rd_nxt = r_rd + DEPTH_BITS'(1);
                end
                // stop wins over advancing. A coincident consume is still counted above.
                if (bus.stop) begin
                    w_state_nxt = ST_DONE;
                end else if (w_fetch_rise) begin
                    if (w_pc_inc < r_len) begin
                        w_pc_nxt    = w_pc_inc[DEPTH_BITS-1:0];
                        w_instr_nxt = w_mem_word;
                    end else begin
`ifdef TRACE_LOOP_EN
                        w_pc_nxt    = '0;
                        w_instr_nxt = r_mem[0];
                        w_rd_nxt    = '0;
                        w_wr_nxt    = '0;
                        if (r_wrap != 8'hFF)
                            w_wrap_nxt = r_wrap + 8'd1;
`else
                        w_state_nxt = ST_DONE;
`endif
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.instruction = r_instr;
    assign bus.halt        = (r_state != ST_RUN);
    assign bus.done        = (r_state == ST_DONE);
    assign bus.prog_count  = r_pc;
    assign bus.read_count  = r_rd;
    assign bus.write_count = r_wr;
`ifdef TRACE_LOOP_EN
    assign bus.wrap_count  = r_wrap;
`else
    // Without looping a pass never completes, so the wrap counter is unused.
    assign bus.wrap_count  = 8'd0;
`endif

endmodule

// File: tb/tb_trace_sequencer.sv
// Directed bench for trace_sequencer: playback, the fetch edge rule, stop, load lockout, reset and the optional loop.
// Expected values are hand-computed. Build with or without TRACE_LOOP_EN.
module tb_trace_sequencer;
    localparam int NPA = 32;
    localparam int DB  = 14;

    logic clk;
    logic reset;
    int   nchecks;
    int   nerr;

    trace_sequencer_if #(.N_PA_BITS(NPA), .DEPTH_BITS(DB)) bus ();

    trace_sequencer #(.N_PA_BITS(NPA), .DEPTH_BITS(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [DB-1:0] a, input logic [NPA:0] d);
        bus.load_en   = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        step();
        bus.load_en   = 1'b0;
    endtask

    task automatic do_start(input logic [DB:0] len);
        bus.trace_len = len;
        bus.start     = 1'b1;
        step();
        bus.start     = 1'b0;
    endtask

    task automatic do_stop();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
    endtask

    task automatic pulse();
        bus.fetch = 1'b1;
        step();
        bus.fetch = 1'b0;
        step();
        step();
        step();
    endtask

    initial begin
        nchecks = 0;
        nerr    = 0;
        reset   = 1'b0;
        bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
        bus.trace_len = '0; bus.start = 1'b0; bus.stop = 1'b0; bus.fetch = 1'b0;
        step(); step();
        chk("rst_halt", bus.halt, 1);
        chk("rst_done", bus.done, 0);
        chk("rst_instr", bus.instruction, 0);
        chk("rst_pc", bus.prog_count, 0);
        chk("rst_cnt", {bus.read_count, bus.write_count, bus.wrap_count}, 0);
        reset = 1'b1;
        step();

        load(0, 33'h0_00000010);
        load(1, 33'h1_00000010);
        load(2, 33'h0_00010020);
        load(3, 33'h1_00000030);
        do_start(4);
        chk("start_instr", bus.instruction, 33'h0_00000010);
        chk("start_halt", bus.halt, 0);
        chk("start_pc", bus.prog_count, 0);

        pulse();
        chk("p1_pc", bus.prog_count, 1);
        chk("p1_instr", bus.instruction, 33'h1_00000010);
        pulse();
        chk("p2_pc", bus.prog_count, 2);
        pulse();
        chk("p3_pc", bus.prog_count, 3);
        chk("p3_instr", bus.instruction, 33'h1_00000030);
        pulse();
`ifdef TRACE_LOOP_EN
        chk("p4_halt", bus.halt, 0);
        chk("p4_done", bus.done, 0);
        chk("p4_pc", bus.prog_count, 0);
        chk("p4_rw", {bus.read_count, bus.write_count}, 0);
        chk("p4_wrap", bus.wrap_count, 1);
`else
        chk("p4_halt", bus.halt, 1);
        chk("p4_done", bus.done, 1);
        chk("p4_pc", bus.prog_count, 3);
        chk("p4_rd", bus.read_count, 2);
        chk("p4_wr", bus.write_count, 2);
        chk("p4_wrap", bus.wrap_count, 0);
`endif

        // fetch held high consumes one entry only
        do_stop();
        do_start(4);
        bus.fetch = 1'b1;
        for (int i = 0; i < 10; i++) step();
        bus.fetch = 1'b0;
        step();
        chk("hold_pc", bus.prog_count, 1);
        chk("hold_rd", bus.read_count, 1);
        chk("hold_wr", bus.write_count, 0);

        do_stop();
        chk("stop_done", bus.done, 1);
        chk("stop_pc", bus.prog_count, 1);

        // stop coinciding with the second fetch rise
        do_start(4);
        pulse();
        bus.fetch = 1'b1;
        bus.stop  = 1'b1;
        step();
        bus.fetch = 1'b0;
        bus.stop  = 1'b0;
        chk("sf_done", bus.done, 1);
        chk("sf_halt", bus.halt, 1);
        chk("sf_pc", bus.prog_count, 1);
        chk("sf_sum", 32'(bus.read_count) + 32'(bus.write_count), 2);
        step();
        chk("sf_hold_pc", bus.prog_count, 1);
        chk("sf_hold_wr", bus.write_count, 1);

        do_start(0);
        chk("len0_done", bus.done, 1);
        chk("len0_instr", bus.instruction, 33'h1_00000010);

        // load during RUN is ignored
        do_start(4);
        chk("rl_instr", bus.instruction, 33'h0_00000010);
        load(0, 33'h1_FFFFFFFF);
        do_stop();
        do_start(4);
        chk("rl_replay", bus.instruction, 33'h0_00000010);
        do_stop();

        // load and start together: start sees the old word
        bus.load_en = 1'b1; bus.load_addr = 0; bus.load_data = 33'h1_23456780;
        bus.trace_len = 4; bus.start = 1'b1;
        step();
        bus.load_en = 1'b0; bus.start = 1'b0;
        chk("ls_old", bus.instruction, 33'h0_00000010);
        do_stop();
        do_start(4);
        chk("ls_new", bus.instruction, 33'h1_23456780);

        // asynchronous reset mid-run
        pulse();
        chk("pre_rst_wr", bus.write_count, 1);
        reset = 1'b0;
        #1;
        chk("ar_halt", bus.halt, 1);
        chk("ar_done", bus.done, 0);
        chk("ar_cnt", {bus.prog_count, bus.read_count, bus.write_count}, 0);
        chk("ar_instr", bus.instruction, 0);
        step();
        reset = 1'b1;
        step();

        // two-entry trace, five fetch pulses
        do_start(2);
        for (int i = 0; i < 5; i++) pulse();
`ifdef TRACE_LOOP_EN
        chk("loop_wrap", bus.wrap_count, 2);
        chk("loop_pc", bus.prog_count, 1);
        chk("loop_halt", bus.halt, 0);
        chk("loop_wr", bus.write_count, 1);
        chk("loop_rd", bus.read_count, 0);
`else
        chk("loop_wrap", bus.wrap_count, 0);
        chk("loop_pc", bus.prog_count, 1);
        chk("loop_halt", bus.halt, 1);
        chk("loop_wr", bus.write_count, 2);
        chk("loop_rd", bus.read_count, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
